// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache memory port arbiter: FSM states and owner codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker between I-cache and D-cache; remembers the last winner.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic update,
  output logic gnt_i,
  output logic gnt_d
);

  owner_e last_q;
  owner_e last_d;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (req_i && req_d) begin
      gnt_d = (last_q == OWN_I);
      gnt_i = (last_q == OWN_D);
    end else begin
      gnt_i = req_i;
      gnt_d = req_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (update && gnt_d) begin
      last_d = OWN_D;
    end else if (update && gnt_i) begin
      last_d = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_I;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one off-chip memory port between I-cache and D-cache, one transaction at a
// time, with registered request/response paths and a sticky no-answer watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              ic_ready_q, ic_ready_d;
  logic              dc_ready_q, dc_ready_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic              err_q, err_d;

  logic dc_req;
  logic idle;
  logic gnt_i;
  logic gnt_d;

  assign dc_req = dc_read | dc_write;
  assign idle   = (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req_i  (ic_read),
    .req_d  (dc_req),
    .update (idle),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_i || gnt_d) state_d = ST_BUSY;
      ST_BUSY: if (mem_ready) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory strobes are dropped on the completion edge, so they never overlap RESP.
  always_comb begin
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    ic_ready_d  = 1'b0;
    dc_ready_d  = 1'b0;
    wd_cnt_d    = '0;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_d) begin
          owner_d     = OWN_D;
          mem_write_d = dc_write;
          mem_read_d  = ~dc_write;
          mem_addr_d  = dc_addr;
          mem_wdata_d = dc_wdata;
        end else if (gnt_i) begin
          owner_d     = OWN_I;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = ic_addr;
          mem_wdata_d = '0;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_q == OWN_I) begin
            ic_ready_d = 1'b1;
            if (mem_read_q) ic_rdata_d = mem_rdata;
          end else begin
            dc_ready_d = 1'b1;
            if (mem_read_q) dc_rdata_d = mem_rdata;
          end
        end else begin
          // Saturate so a hung memory cannot wrap the counter back below the limit.
          wd_cnt_d = (wd_cnt_q == TIMEOUT_C) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);
          if (wd_cnt_d == TIMEOUT_C) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_I;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
      wd_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      ic_ready_q  <= ic_ready_d;
      dc_ready_q  <= dc_ready_d;
      wd_cnt_q    <= wd_cnt_d;
      err_q       <= err_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign ic_rdata    = ic_rdata_q;
  assign dc_rdata    = dc_rdata_q;
  assign ic_ready    = ic_ready_q;
  assign dc_ready    = dc_ready_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level model of arbitration, data return and watchdog.
module tb_mem_arbiter;

  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ic_read;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_ready;
  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              err_timeout;

  int tests = 0;
  int fails = 0;

  // Reference model state: who won last, what each cache should hold, sticky error.
  bit                last_was_d;
  logic [DATA_W-1:0] exp_ic_rdata;
  logic [DATA_W-1:0] exp_dc_rdata;
  bit                exp_err;

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ic_read     (ic_read),
    .ic_addr     (ic_addr),
    .ic_rdata    (ic_rdata),
    .ic_ready    (ic_ready),
    .dc_read     (dc_read),
    .dc_write    (dc_write),
    .dc_addr     (dc_addr),
    .dc_wdata    (dc_wdata),
    .dc_rdata    (dc_rdata),
    .dc_ready    (dc_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    last_was_d   = 1'b0;
    exp_ic_rdata = '0;
    exp_dc_rdata = '0;
    exp_err      = 1'b0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_ic_ready"}, ic_ready, 0);
    checkOutput({tag, "_dc_ready"}, dc_ready, 0);
    checkOutput({tag, "_mem_read"}, mem_read, 0);
    checkOutput({tag, "_mem_write"}, mem_write, 0);
    checkOutput({tag, "_ic_rdata"}, ic_rdata, exp_ic_rdata);
    checkOutput({tag, "_dc_rdata"}, dc_rdata, exp_dc_rdata);
    checkOutput({tag, "_err"}, err_timeout, exp_err);
  endtask

  // One full transaction; lat = number of strobe cycles, mem_ready in the last one.
  task automatic applyStimulus(input string name, input logic ir, input logic dr,
                               input logic dw, input logic [ADDR_W-1:0] ia,
                               input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] wd,
                               input logic [DATA_W-1:0] rd, input int lat);
    bit                win_d;
    bit                exp_rd;
    bit                exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    if (ir && (dr || dw)) win_d = !last_was_d;
    else                  win_d = (dr || dw);
    last_was_d = win_d;
    exp_wr     = win_d && dw;
    exp_rd     = !exp_wr;
    exp_addr   = win_d ? da : ia;

    @(negedge clk);
    ic_read  = ir;
    dc_read  = dr;
    dc_write = dw;
    ic_addr  = ia;
    dc_addr  = da;
    dc_wdata = wd;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      ic_read  = 1'b0;
      dc_read  = 1'b0;
      dc_write = 1'b0;
      ic_addr  = ADDR_W'($urandom());
      dc_addr  = ADDR_W'($urandom());
      dc_wdata = rand_line();
      checkOutput({name, "_mem_read"}, mem_read, exp_rd);
      checkOutput({name, "_mem_write"}, mem_write, exp_wr);
      checkOutput({name, "_mem_addr"}, mem_addr, exp_addr);
      if (exp_wr) checkOutput({name, "_mem_wdata"}, mem_wdata, wd);
      checkOutput({name, "_busy_ic_ready"}, ic_ready, 0);
      checkOutput({name, "_busy_dc_ready"}, dc_ready, 0);
      checkOutput({name, "_busy_err"}, err_timeout, exp_err || (k >= TIMEOUT));
      if (k == lat - 1) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = rand_line();
      end
    end
    if (lat - 1 >= TIMEOUT) exp_err = 1'b1;
    if (!exp_wr) begin
      if (win_d) exp_dc_rdata = rd;
      else       exp_ic_rdata = rd;
    end

    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = rand_line();
    checkOutput({name, "_resp_ic_ready"}, ic_ready, !win_d);
    checkOutput({name, "_resp_dc_ready"}, dc_ready, win_d);
    checkOutput({name, "_resp_mem_read"}, mem_read, 0);
    checkOutput({name, "_resp_mem_write"}, mem_write, 0);
    checkOutput({name, "_resp_ic_rdata"}, ic_rdata, exp_ic_rdata);
    checkOutput({name, "_resp_dc_rdata"}, dc_rdata, exp_dc_rdata);
    checkOutput({name, "_resp_err"}, err_timeout, exp_err);

    @(negedge clk);
    checkQuiet({name, "_idle"});
  endtask

  initial begin
    logic ir, dr, dw;

    // Reset asserted while every requester is active.
    rst       = 1'b0;
    ic_read   = 1'b1;
    dc_read   = 1'b1;
    dc_write  = 1'b1;
    ic_addr   = 28'h0000040;
    dc_addr   = 28'h0000080;
    dc_wdata  = rand_line();
    mem_rdata = rand_line();
    mem_ready = 1'b1;
    modelReset();
    repeat (3) @(negedge clk);
    checkQuiet("reset");
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_mem_wdata", mem_wdata, 0);
    ic_read   = 1'b0;
    dc_read   = 1'b0;
    dc_write  = 1'b0;
    mem_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checkQuiet("post_reset");

    applyStimulus("ic_only", 1, 0, 0, 28'h0000040, 28'h0, '0,
                  {4{32'hA5A5A5A5}}, 3);

    applyStimulus("tie1", 1, 1, 0, 28'h0000100, 28'h0000200, '0, rand_line(), 1);
    applyStimulus("tie_then_i", 1, 0, 0, 28'h0000100, 28'h0, '0, rand_line(), 2);
    applyStimulus("tie2", 1, 1, 0, 28'h0000300, 28'h0000400, '0, rand_line(), 1);

    applyStimulus("wr_and_rd", 0, 1, 1, 28'h0, 28'h0ABCDEF,
                  {4{32'h12345678}}, rand_line(), 2);

    // mem_ready while idle must be ignored.
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = rand_line();
    @(negedge clk);
    mem_ready = 1'b0;
    checkQuiet("stray_ready");

    // Longest latency that must not trip the watchdog.
    applyStimulus("wd_edge", 0, 1, 0, 28'h0, 28'h0001234, '0, rand_line(), TIMEOUT);

    for (int n = 0; n < 30; n++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      if (!ir && !dr && !dw) ir = 1'b1;
      applyStimulus($sformatf("rand%0d", n), ir, dr, dw, ADDR_W'($urandom()),
                    ADDR_W'($urandom()), rand_line(), rand_line(),
                    int'($urandom_range(1, TIMEOUT)));
    end

    applyStimulus("timeout", 1, 0, 0, 28'h0005555, 28'h0, '0, rand_line(), TIMEOUT + 3);
    applyStimulus("after_timeout", 0, 1, 0, 28'h0, 28'h0006666, '0, rand_line(), 1);

    // Reset in the middle of a transaction drops the strobes without a clock edge.
    @(negedge clk);
    ic_read = 1'b1;
    ic_addr = 28'h0007777;
    @(negedge clk);
    ic_read = 1'b0;
    checkOutput("rst_mid_busy", mem_read, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_async_read", mem_read, 0);
    checkOutput("rst_async_write", mem_write, 0);
    checkOutput("rst_async_err", err_timeout, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkQuiet("rst_release");
    end
    applyStimulus("tie_after_rst", 1, 1, 0, 28'h0000010, 28'h0000020, '0, rand_line(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
